// File: rtl/sbio2_pkg.sv
// Shared types and helpers for the sbio2 serial RAM responder.
// SBIO2_RESP_PARITY_EN adds a trailing even-parity cycle to rx frames and tx responses.
package sbio2_pkg;

    localparam int START_BIT = 0;
    localparam int WR_BIT    = 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ADDR,
        RX_DATA,
        RX_PAR
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_START,
        TX_DATA,
        TX_PAR
    } tx_state_t;

`ifdef SBIO2_RESP_PARITY_EN
    localparam int PAR_CYCLES = 1;
`else
    localparam int PAR_CYCLES = 0;
`endif

    function automatic int beats(input int bits, input int io);
        return bits / io;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sbio2_serializer.sv
// Emits start marker, then a data word IO_BITS per cycle LSB first.
// SBIO2_RESP_PARITY_EN appends one even-parity cycle after the data.
module sbio2_serializer
    import sbio2_pkg::*;
#(
    parameter int IO_BITS   = 2,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic [IO_BITS-1:0]   tx_pins,
    output logic                 done
);

    localparam int BEATS = beats(DATA_BITS, IO_BITS);
    localparam int CW    = cnt_w(BEATS);

    tx_state_t            st;
    logic [DATA_BITS-1:0] sr;
    logic [CW-1:0]        cnt;
    logic                 last;

    assign last = (cnt == CW'(BEATS - 1));

`ifdef SBIO2_RESP_PARITY_EN
    logic par;
    assign done = (st == TX_PAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par <= 1'b0;
        else if (st == TX_IDLE && start)
            par <= ^data;
    end
`else
    assign done = (st == TX_DATA) && last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= TX_IDLE;
            sr      <= '0;
            cnt     <= '0;
            tx_pins <= '0;
        end else begin
            unique case (st)
                TX_IDLE: begin
                    if (start) begin
                        sr      <= data;
                        cnt     <= '0;
                        tx_pins <= IO_BITS'(1);
                        st      <= TX_START;
                    end
                end
                TX_START: begin
                    tx_pins <= sr[IO_BITS-1:0];
                    sr      <= sr >> IO_BITS;
                    st      <= TX_DATA;
                end
                TX_DATA: begin
                    if (last) begin
`ifdef SBIO2_RESP_PARITY_EN
                        tx_pins <= IO_BITS'(par);
                        st      <= TX_PAR;
`else
                        tx_pins <= '0;
                        st      <= TX_IDLE;
`endif
                    end else begin
                        tx_pins <= sr[IO_BITS-1:0];
                        sr      <= sr >> IO_BITS;
                        cnt     <= cnt + 1'b1;
                    end
                end
                TX_PAR: begin
                    tx_pins <= '0;
                    st      <= TX_IDLE;
                end
                default: st <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sbio2_ram_responder.sv
// Responder end of the sbio2 serial RAM link: rx command frames into a word RAM.
// Read data returns on tx_pins after RESP_DELAY idle cycles; SBIO2_RESP_PARITY_EN enables parity.
module sbio2_ram_responder
    import sbio2_pkg::*;
#(
    parameter int IO_BITS    = 2,
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 16,
    parameter int RESP_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IO_BITS-1:0]   rx_pins,
    output logic [IO_BITS-1:0]   tx_pins,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [DATA_BITS-1:0] init_data,
    output logic                 busy,
    output logic                 overrun,
    output logic [15:0]          frame_count,
    output logic [7:0]           err_count
);

    localparam int ADDR_CYC = beats(ADDR_BITS, IO_BITS);
    localparam int DATA_CYC = beats(DATA_BITS, IO_BITS);
    localparam int MAX_CYC  = (ADDR_CYC > DATA_CYC) ? ADDR_CYC : DATA_CYC;
    localparam int RC_W     = cnt_w(MAX_CYC);
    localparam int DW       = cnt_w(RESP_DELAY);
`ifdef SBIO2_RESP_PARITY_EN
    localparam rx_state_t RX_END = RX_PAR;
`else
    localparam rx_state_t RX_END = RX_IDLE;
`endif

    rx_state_t            rx_st;
    tx_state_t            tx_st;
    logic                 wr_q;
    logic [RC_W-1:0]      rx_cnt;
    logic [ADDR_BITS-1:0] addr_sr, addr_nx, c_addr;
    logic [DATA_BITS-1:0] data_sr, data_nx, c_data;
    logic                 addr_last, data_last;
    logic                 wr_go, rd_go, rd_pend;
    logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];
    logic [DATA_BITS-1:0] rd_data, resp;
    logic [DW-1:0]        dly;
    logic                 ser_start, ser_done;

    assign addr_nx   = ADDR_BITS'({rx_pins, addr_sr} >> IO_BITS);
    assign data_nx   = DATA_BITS'({rx_pins, data_sr} >> IO_BITS);
    assign addr_last = (rx_st == RX_ADDR) && (rx_cnt == RC_W'(ADDR_CYC - 1));
    assign data_last = (rx_st == RX_DATA) && (rx_cnt == RC_W'(DATA_CYC - 1));
    assign busy      = (rx_st != RX_IDLE) || (tx_st != TX_IDLE);
    assign ser_start = (tx_st == TX_WAIT) && (dly == DW'(RESP_DELAY - 1));

`ifdef SBIO2_RESP_PARITY_EN
    logic       par_q;
    logic [7:0] err_q;

    assign err_count = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
            err_q <= '0;
        end else begin
            unique case (rx_st)
                RX_IDLE: par_q <= rx_pins[WR_BIT];
                RX_ADDR,
                RX_DATA: par_q <= par_q ^ (^rx_pins);
                RX_PAR:  if (rx_pins[0] != par_q && err_q != 8'hFF)
                             err_q <= err_q + 8'd1;
                default: par_q <= 1'b0;
            endcase
        end
    end
`else
    assign err_count = '0;
`endif

    // Commit point: the cycle that completes a frame (parity cycle when enabled).
    always_comb begin
        wr_go  = 1'b0;
        rd_go  = 1'b0;
        c_addr = addr_sr;
        c_data = data_sr;
`ifdef SBIO2_RESP_PARITY_EN
        if (rx_st == RX_PAR && rx_pins[0] == par_q) begin
            wr_go = wr_q;
            rd_go = !wr_q;
        end
`else
        if (addr_last && !wr_q) begin
            rd_go  = 1'b1;
            c_addr = addr_nx;
        end
        if (data_last) begin
            wr_go  = 1'b1;
            c_data = data_nx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st       <= RX_IDLE;
            wr_q        <= 1'b0;
            rx_cnt      <= '0;
            addr_sr     <= '0;
            data_sr     <= '0;
            frame_count <= '0;
        end else begin
            unique case (rx_st)
                RX_IDLE: begin
                    if (rx_pins[START_BIT]) begin
                        wr_q   <= rx_pins[WR_BIT];
                        rx_cnt <= '0;
                        rx_st  <= RX_ADDR;
                    end
                end
                RX_ADDR: begin
                    addr_sr <= addr_nx;
                    if (addr_last) begin
                        rx_cnt <= '0;
                        rx_st  <= wr_q ? RX_DATA : RX_END;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    data_sr <= data_nx;
                    if (data_last) rx_st <= RX_END;
                    else           rx_cnt <= rx_cnt + 1'b1;
                end
                RX_PAR:  rx_st <= RX_IDLE;
                default: rx_st <= RX_IDLE;
            endcase
            if (wr_go || rd_go)
                frame_count <= frame_count + 16'd1;
        end
    end

    // Word RAM is not reset; rx write wins over a same-cycle preload.
    always_ff @(posedge clk) begin
        if (wr_go)
            mem[c_addr] <= c_data;
        else if (init_we)
            mem[init_addr] <= init_data;
        rd_data <= mem[c_addr];
    end

    // TX_START here means the serializer owns the line until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st   <= TX_IDLE;
            rd_pend <= 1'b0;
            resp    <= '0;
            dly     <= '0;
            overrun <= 1'b0;
        end else begin
            rd_pend <= rd_go;
            if (rd_pend && tx_st != TX_IDLE)
                overrun <= 1'b1;
            unique case (tx_st)
                TX_IDLE: begin
                    if (rd_pend) begin
                        resp  <= rd_data;
                        dly   <= '0;
                        tx_st <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (ser_start) tx_st <= TX_START;
                    else           dly <= dly + 1'b1;
                end
                TX_START: if (ser_done) tx_st <= TX_IDLE;
                default:  tx_st <= TX_IDLE;
            endcase
        end
    end

    sbio2_serializer #(
        .IO_BITS   (IO_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (ser_start),
        .data    (resp),
        .tx_pins (tx_pins),
        .done    (ser_done)
    );

endmodule
